// File: rtl/fetch_pkg.sv
`default_nettype none
// fetch_pkg: shared types for the fetch stage (occupancy state, IR/skid entry, IR reset value).
// Revision 1.0
package fetch_pkg;

   localparam int unsigned FETCH_D = 8;
   localparam int unsigned FETCH_W = 9;

   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      FULL  = 2'd1,
      SKID  = 2'd2
   } fetch_state_t;

   typedef struct packed {
      logic [FETCH_W-1:0] word;
      logic [FETCH_D-1:0] pc;
   } fetch_entry_t;

   // The all-zero word doubles as a NOP, so a reset IR is harmless to decode.
   localparam logic [FETCH_W-1:0] IR_RESET_WORD = '0;
   localparam fetch_entry_t       IR_RESET      = '{word: IR_RESET_WORD, pc: '0};

endpackage
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// fetch_unit: tags ROM reads with their PC, registers them into the IR, absorbs decode stalls
// with a one-entry skid buffer and squashes wrong-path words on redirect. Revision 1.0
module fetch_unit
   import fetch_pkg::*;
#(
   parameter int D = FETCH_D,
   parameter int W = FETCH_W
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [D-1:0] prog_ctr,
   input  logic         redirect,
   output logic [D-1:0] imem_addr,
   input  logic [W-1:0] imem_rdata,
   input  logic         id_ready,
   output logic [W-1:0] instr,
   output logic [D-1:0] instr_pc,
   output logic         instr_valid,
   output logic         pc_hold
);

   fetch_state_t state_q;
   logic         req_v_q;
   logic [D-1:0] req_pc_q;
   fetch_entry_t ir_q;
   fetch_entry_t skid_q;

   logic         accept;
   logic         arrive;
   fetch_entry_t in_entry;

   assign imem_addr   = prog_ctr;
   assign instr       = ir_q.word;
   assign instr_pc    = ir_q.pc;
   assign instr_valid = (state_q != EMPTY);

   assign accept   = instr_valid & id_ready;
   assign arrive   = req_v_q & ~redirect;
   assign in_entry = '{word: imem_rdata, pc: req_pc_q};

   // Holding whenever the next arrival could not be stored keeps at most one word in flight.
   assign pc_hold = ((state_q == FULL) & ~id_ready) | (state_q == SKID);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= EMPTY;
         req_v_q  <= 1'b0;
         req_pc_q <= '0;
         ir_q     <= IR_RESET;
         skid_q   <= IR_RESET;
      end else begin
         req_v_q  <= ~pc_hold & ~redirect;
         req_pc_q <= prog_ctr;

         case (state_q)
            EMPTY: begin
               if (arrive) begin
                  ir_q    <= in_entry;
                  state_q <= FULL;
               end
            end
            FULL: begin
               if (accept && arrive) begin
                  ir_q <= in_entry;
               end else if (accept) begin
                  state_q <= EMPTY;
               end else if (arrive) begin
                  skid_q  <= in_entry;
                  state_q <= SKID;
               end
            end
            SKID: begin
               // A redirect discards the skid word; the IR survives unless decode takes it now.
               if (redirect) begin
                  state_q <= accept ? EMPTY : FULL;
               end else if (accept) begin
                  ir_q    <= skid_q;
                  state_q <= FULL;
               end
            end
            default: begin
               state_q <= EMPTY;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// tb_fetch_unit: directed and random stimulus against an in-order instruction stream model.
// Revision 1.0
module tb_fetch_unit;

   localparam int D = 8;
   localparam int W = 9;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic         redirect = 1'b0;
   logic         id_ready = 1'b0;
   logic [D-1:0] prog_ctr = '0;
   logic [D-1:0] imem_addr;
   logic [W-1:0] imem_rdata = '0;
   logic [W-1:0] instr;
   logic [D-1:0] instr_pc;
   logic         instr_valid;
   logic         pc_hold;

   int checks = 0;
   int errors = 0;
   int n_acc  = 0;

   // Environment PC and the expected in-order program stream.
   logic [D-1:0] pc_m = '0;
   logic [D-1:0] exp_q[$];
   logic [D-1:0] exp_next = '0;

   logic         s_valid;
   logic         s_hold;
   logic [D-1:0] s_pc;
   logic [W-1:0] s_instr;

   always #5 clk = ~clk;

   fetch_unit #(.D(D), .W(W)) dut (
      .clk        (clk),
      .reset      (reset),
      .prog_ctr   (prog_ctr),
      .redirect   (redirect),
      .imem_addr  (imem_addr),
      .imem_rdata (imem_rdata),
      .id_ready   (id_ready),
      .instr      (instr),
      .instr_pc   (instr_pc),
      .instr_valid(instr_valid),
      .pc_hold    (pc_hold)
   );

   function automatic logic [W-1:0] rom_word(input logic [D-1:0] a);
      return {1'b1, a};
   endfunction

   always @(posedge clk) imem_rdata <= rom_word(imem_addr);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      exp_next = '0;
      pc_m     = '0;
      prog_ctr = '0;
   endtask

   // One clock cycle: drive, sample mid-cycle, check accepted words against the stream, advance PC.
   task automatic cycle(input logic rdy, input logic redir, input logic [D-1:0] tgt);
      logic [D-1:0] ex;
      id_ready = rdy;
      redirect = redir;
      #1;
      s_valid = instr_valid;
      s_hold  = pc_hold;
      s_pc    = instr_pc;
      s_instr = instr;
      ex = (exp_q.size() > 0) ? exp_q[0] : exp_next;
      if (s_valid && rdy) begin
         chk("stream_pc", {24'd0, s_pc}, {24'd0, ex});
         chk("stream_word", {23'd0, s_instr}, {23'd0, rom_word(ex)});
         if (exp_q.size() > 0) void'(exp_q.pop_front());
         else exp_next = exp_next + 1'b1;
         n_acc++;
      end
      if (redir) begin
         exp_q.delete();
         if (s_valid && !rdy) exp_q.push_back(ex);
         exp_next = tgt;
      end
      @(posedge clk);
      #1;
      if (redir) pc_m = tgt;
      else if (!s_hold) pc_m = pc_m + 1'b1;
      prog_ctr = pc_m;
   endtask

   task automatic next_valid(input string tag, input logic [D-1:0] exp_pc, input int bound);
      int n;
      n = 0;
      do begin
         cycle(1'b1, 1'b0, '0);
         n++;
      end while (!s_valid && n < bound);
      chk({tag, "_valid"}, {31'd0, s_valid}, 32'd1);
      chk({tag, "_pc"}, {24'd0, s_pc}, {24'd0, exp_pc});
      chk({tag, "_word"}, {23'd0, s_instr}, {23'd0, rom_word(exp_pc)});
   endtask

   initial begin
      int acc_before;
      #2 reset = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", {31'd0, instr_valid}, 32'd0);
      chk("rst_instr", {23'd0, instr}, 32'd0);
      chk("rst_pc", {24'd0, instr_pc}, 32'd0);
      chk("rst_hold", {31'd0, pc_hold}, 32'd0);

      // Reset release: first instruction two cycles later, then one per cycle.
      reset = 1'b1;
      model_reset();
      cycle(1'b1, 1'b0, '0);
      chk("lat_c0_valid", {31'd0, s_valid}, 32'd0);
      cycle(1'b1, 1'b0, '0);
      chk("lat_c1_valid", {31'd0, s_valid}, 32'd0);
      cycle(1'b1, 1'b0, '0);
      chk("lat_c2_valid", {31'd0, s_valid}, 32'd1);
      chk("lat_c2_pc", {24'd0, s_pc}, 32'h0);
      chk("lat_c2_instr", {23'd0, s_instr}, 32'h100);
      for (int i = 1; i <= 3; i++) begin
         cycle(1'b1, 1'b0, '0);
         chk("tput_valid", {31'd0, s_valid}, 32'd1);
         chk("tput_pc", {24'd0, s_pc}, i);
      end

      // Decode stall at pc 5 for three cycles, skid absorbs pc 6.
      cycle(1'b1, 1'b0, '0);
      for (int i = 0; i < 3; i++) begin
         cycle(1'b0, 1'b0, '0);
         chk("stall_pc", {24'd0, s_pc}, 32'h5);
         chk("stall_valid", {31'd0, s_valid}, 32'd1);
         chk("stall_hold", {31'd0, s_hold}, 32'd1);
      end
      cycle(1'b1, 1'b0, '0);
      chk("release_pc", {24'd0, s_pc}, 32'h5);
      next_valid("release6", 8'h06, 4);
      next_valid("release7", 8'h07, 4);

      // Redirect to 0x40 while IR shows 0x10.
      for (int i = 0; i < 40 && pc_m != 8'h12; i++) cycle(1'b1, 1'b0, '0);
      cycle(1'b1, 1'b1, 8'h40);
      chk("redir_cur_pc", {24'd0, s_pc}, 32'h10);
      cycle(1'b1, 1'b0, '0);
      chk("redir_bubble1", {31'd0, s_valid}, 32'd0);
      cycle(1'b1, 1'b0, '0);
      chk("redir_bubble2", {31'd0, s_valid}, 32'd0);
      cycle(1'b1, 1'b0, '0);
      chk("redir_tgt_valid", {31'd0, s_valid}, 32'd1);
      chk("redir_tgt_pc", {24'd0, s_pc}, 32'h40);
      chk("redir_tgt_instr", {23'd0, s_instr}, 32'h140);

      // Redirect while the skid is occupied and decode is stalled.
      cycle(1'b0, 1'b0, '0);
      chk("skid_fill_pc", {24'd0, s_pc}, 32'h41);
      chk("skid_fill_hold", {31'd0, s_hold}, 32'd1);
      cycle(1'b0, 1'b1, 8'h80);
      chk("skid_redir_pc", {24'd0, s_pc}, 32'h41);
      chk("skid_redir_hold", {31'd0, s_hold}, 32'd1);
      cycle(1'b0, 1'b0, '0);
      chk("skid_keep_valid", {31'd0, s_valid}, 32'd1);
      chk("skid_keep_pc", {24'd0, s_pc}, 32'h41);
      cycle(1'b1, 1'b0, '0);
      chk("skid_accept_pc", {24'd0, s_pc}, 32'h41);
      next_valid("skid_tgt", 8'h80, 6);

      // Asynchronous reset in the middle of a cycle.
      repeat (3) cycle(1'b1, 1'b0, '0);
      #2 reset = 1'b0;
      #1;
      chk("arst_valid", {31'd0, instr_valid}, 32'd0);
      chk("arst_instr", {23'd0, instr}, 32'd0);
      chk("arst_pc", {24'd0, instr_pc}, 32'd0);
      chk("arst_hold", {31'd0, pc_hold}, 32'd0);
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b1;
      model_reset();
      next_valid("restart", 8'h00, 4);

      // Address wrap-around.
      cycle(1'b1, 1'b1, 8'hFE);
      next_valid("wrap_fe", 8'hFE, 5);
      cycle(1'b1, 1'b0, '0);
      chk("wrap_ff_pc", {24'd0, s_pc}, 32'hFF);
      chk("wrap_ff_instr", {23'd0, s_instr}, 32'h1FF);
      cycle(1'b1, 1'b0, '0);
      chk("wrap_00_pc", {24'd0, s_pc}, 32'h00);
      chk("wrap_00_instr", {23'd0, s_instr}, 32'h100);

      // Random stalls and redirects, every accepted word checked against the stream.
      acc_before = n_acc;
      for (int i = 0; i < 400; i++) begin
         cycle($urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0, D'($urandom_range(0, 255)));
      end
      repeat (8) cycle(1'b1, 1'b0, '0);
      chk("random_progress", {31'd0, (n_acc - acc_before) >= 60}, 32'd1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

endmodule
`default_nettype wire
